// File: rtl/dual_port_ram_param.sv
// dual_port_ram_param: single-clock true dual-port RAM with per-byte write
// enables, selectable same-port read-during-write mode, write-write collision
// resolution (port A wins on overlapping bytes) and a post-reset clear
// sequencer that zeroes every word before the ports are accepted.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   init_done           1 once the clear sequence has finished
//   a_en/a_we/a_be      port A enable, write, byte enables
//   a_addr/a_din        port A word address, write data
//   a_dout              port A registered read data
//   b_*                 identical set for port B
//   coll                registered write-write collision pulse
//
// Optional build macro: DPRAM_OUT_REG_EN adds an output register stage on
// a_dout/b_dout (read latency 2) and delays coll by the same cycle.
module dual_port_ram_param #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned READ_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  init_done,
    input  logic                  a_en,
    input  logic                  a_we,
    input  logic [DATA_W/8-1:0]   a_be,
    input  logic [ADDR_W-1:0]     a_addr,
    input  logic [DATA_W-1:0]     a_din,
    output logic [DATA_W-1:0]     a_dout,
    input  logic                  b_en,
    input  logic                  b_we,
    input  logic [DATA_W/8-1:0]   b_be,
    input  logic [ADDR_W-1:0]     b_addr,
    input  logic [DATA_W-1:0]     b_din,
    output logic [DATA_W-1:0]     b_dout,
    output logic                  coll
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   cnt_q;
    logic                init_done_q;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                rdy_c;
    logic                a_wr_c;
    logic                b_wr_c;
    logic [DATA_W-1:0]   a_rd_c;
    logic [DATA_W-1:0]   b_rd_c;

    logic [DATA_W-1:0]   a_dout_q;
    logic [DATA_W-1:0]   b_dout_q;
    logic                coll_q;

    // Clear sequencer: one word per cycle, then READY until next reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q     <= ST_READY;
                        init_done_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + ADDR_W'(1);
                    end
                end
                ST_READY: begin
                    state_q <= ST_READY;
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    // Port qualification and same-port read data (write-first merges own bytes).
    always_comb begin
        rdy_c  = (state_q == ST_READY);
        a_wr_c = rdy_c & a_en & a_we;
        b_wr_c = rdy_c & b_en & b_we;
        a_rd_c = mem[a_addr];
        b_rd_c = mem[b_addr];
        if (READ_MODE == 1) begin
            for (int i = 0; i < BE_W; i++) begin
                if (a_we && a_be[i]) a_rd_c[8*i +: 8] = a_din[8*i +: 8];
                if (b_we && b_be[i]) b_rd_c[8*i +: 8] = b_din[8*i +: 8];
            end
        end
    end

    // Storage: B bytes are written first so that A overrides overlapping bytes.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            mem[cnt_q] <= '0;
        end else begin
            for (int i = 0; i < BE_W; i++) begin
                if (b_wr_c && b_be[i]) mem[b_addr][8*i +: 8] <= b_din[8*i +: 8];
                if (a_wr_c && a_be[i]) mem[a_addr][8*i +: 8] <= a_din[8*i +: 8];
            end
        end
    end

    // Read registers and collision flag; all frozen at 0 during the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_dout_q <= '0;
            b_dout_q <= '0;
            coll_q   <= 1'b0;
        end else if (rdy_c) begin
            if (a_en) a_dout_q <= a_rd_c;
            if (b_en) b_dout_q <= b_rd_c;
            coll_q <= a_wr_c & b_wr_c & (a_addr == b_addr) & (|(a_be & b_be));
        end
    end

`ifdef DPRAM_OUT_REG_EN
    logic [DATA_W-1:0] a_dout_q2;
    logic [DATA_W-1:0] b_dout_q2;
    logic              coll_q2;

    // Extra output stage; coll is delayed alongside so it stays aligned with dout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_dout_q2 <= '0;
            b_dout_q2 <= '0;
            coll_q2   <= 1'b0;
        end else if (rdy_c) begin
            a_dout_q2 <= a_dout_q;
            b_dout_q2 <= b_dout_q;
            coll_q2   <= coll_q;
        end
    end

    assign a_dout = a_dout_q2;
    assign b_dout = b_dout_q2;
    assign coll   = coll_q2;
`else
    assign a_dout = a_dout_q;
    assign b_dout = b_dout_q;
    assign coll   = coll_q;
`endif

    assign init_done = init_done_q;

endmodule

// File: tb/tb_dual_port_ram_param.sv
module tb_dual_port_ram_param;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 4;
    localparam int unsigned RM = 0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          init_done;
    logic          a_en = 1'b0, a_we = 1'b0;
    logic [1:0]    a_be = 2'b00;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_din = '0;
    logic [DW-1:0] a_dout;
    logic          b_en = 1'b0, b_we = 1'b0;
    logic [1:0]    b_be = 2'b00;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_din = '0;
    logic [DW-1:0] b_dout;
    logic          coll;

    int tests  = 0;
    int errors = 0;

    dual_port_ram_param #(.DATA_W(DW), .ADDR_W(AW), .READ_MODE(RM)) dut (
        .clk(clk), .rst_n(rst_n), .init_done(init_done),
        .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout),
        .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout),
        .coll(coll)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] din,
                                            input logic [1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < 2; i++) if (be[i]) r[8*i +: 8] = din[8*i +: 8];
        return r;
    endfunction

    // Behavioural model: word array, clear modelled as "16 cycles then all zero".
    logic [DW-1:0] m_mem [16];
    logic          m_ready;
    int            m_cnt;
    logic [DW-1:0] e_a, e_b;
    logic          e_coll;
    logic [DW-1:0] old_a, old_b;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready = 1'b0;
            m_cnt   = 0;
            e_a     = '0;
            e_b     = '0;
            e_coll  = 1'b0;
        end else if (!m_ready) begin
            m_cnt++;
            if (m_cnt == 16) begin
                m_ready = 1'b1;
                foreach (m_mem[i]) m_mem[i] = '0;
            end
        end else begin
            old_a = m_mem[a_addr];
            old_b = m_mem[b_addr];
            if (a_en) e_a = (a_we && RM == 1) ? merge(old_a, a_din, a_be) : old_a;
            if (b_en) e_b = (b_we && RM == 1) ? merge(old_b, b_din, b_be) : old_b;
            e_coll = a_en && a_we && b_en && b_we && (a_addr == b_addr) && ((a_be & b_be) != 2'b00);
            if (b_en && b_we) m_mem[b_addr] = merge(m_mem[b_addr], b_din, b_be);
            if (a_en && a_we) m_mem[a_addr] = merge(m_mem[a_addr], a_din, a_be);
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_init_done", 32'(init_done), 32'(m_ready));
            chk("model_a_dout", 32'(a_dout), 32'(e_a));
            chk("model_b_dout", 32'(b_dout), 32'(e_b));
            chk("model_coll", 32'(coll), 32'(e_coll));
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        a_en = 1'b0; a_we = 1'b0; a_be = 2'b00;
        b_en = 1'b0; b_we = 1'b0; b_be = 2'b00;
    endtask

    task automatic a_set(input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] d, input logic [1:0] be);
        a_en = 1'b1; a_we = we; a_addr = ad; a_din = d; a_be = be;
    endtask

    task automatic b_set(input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] d, input logic [1:0] be);
        b_en = 1'b1; b_we = we; b_addr = ad; b_din = d; b_be = be;
    endtask

    // Count cycles from the current point until init_done rises, bounded.
    task automatic measure_init(input string name);
        int n;
        n = 0;
        while (!init_done && n < 40) begin
            tick();
            n++;
        end
        chk(name, 32'(n), 32'd16);
    endtask

    initial begin
        idle();
        tick();
        tick();
        chk("reset_a_dout", 32'(a_dout), 32'h0);
        chk("reset_init_done", 32'(init_done), 32'h0);
        rst_n = 1'b1;

        // 1. clear length and all-zero contents
        measure_init("init_cycles");
        for (int i = 0; i < 16; i++) begin
            idle();
            a_set(1'b0, AW'(i), '0, 2'b00);
            tick();
            chk("clear_read", 32'(a_dout), 32'h0000);
        end

        // 2. A writes, B reads the same word
        idle(); a_set(1'b1, 4'd3, 16'hA5A5, 2'b11); tick();
        idle(); b_set(1'b0, 4'd3, '0, 2'b00); tick();
        chk("xport_read", 32'(b_dout), 32'hA5A5);

        // 3. concurrent writes to different addresses
        idle(); a_set(1'b1, 4'd2, 16'h5555, 2'b11); b_set(1'b1, 4'd6, 16'hCCCC, 2'b11); tick();
        chk("diff_addr_coll", 32'(coll), 32'h0);
        idle(); a_set(1'b0, 4'd6, '0, 2'b00); b_set(1'b0, 4'd2, '0, 2'b00); tick();
        chk("a_read6", 32'(a_dout), 32'hCCCC);
        chk("b_read2", 32'(b_dout), 32'h5555);

        // 4. byte enables and be=0 no-op
        idle(); a_set(1'b1, 4'd5, 16'h1234, 2'b11); tick();
        idle(); a_set(1'b1, 4'd5, 16'hABCD, 2'b01); tick();
        idle(); a_set(1'b0, 4'd5, '0, 2'b00); tick();
        chk("be01_read", 32'(a_dout), 32'h12CD);
        idle(); a_set(1'b1, 4'd5, 16'hFFFF, 2'b00); tick();
        idle(); a_set(1'b0, 4'd5, '0, 2'b00); tick();
        chk("be00_read", 32'(a_dout), 32'h12CD);

        // 5. write-write collisions
        idle(); a_set(1'b1, 4'd7, 16'h1111, 2'b11); b_set(1'b1, 4'd7, 16'h2222, 2'b10); tick();
        chk("coll_pulse", 32'(coll), 32'h1);
        idle(); tick();
        chk("coll_drop", 32'(coll), 32'h0);
        idle(); a_set(1'b0, 4'd7, '0, 2'b00); tick();
        chk("coll_a_wins", 32'(a_dout), 32'h1111);
        idle(); a_set(1'b1, 4'd7, 16'h1111, 2'b01); b_set(1'b1, 4'd7, 16'h2222, 2'b10); tick();
        chk("no_overlap_coll", 32'(coll), 32'h0);
        idle(); b_set(1'b0, 4'd7, '0, 2'b00); tick();
        chk("merged_bytes", 32'(b_dout), 32'h2211);

        // 6. same-port read-during-write, then reset mid-clear
        idle(); a_set(1'b1, 4'd1, 16'h0000, 2'b11); tick();
        idle(); a_set(1'b1, 4'd1, 16'h00FF, 2'b11); tick();
        chk("rdw_same_port", 32'(a_dout), (RM == 0) ? 32'h0000 : 32'h00FF);
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("mid_clear_not_done", 32'(init_done), 32'h0);
        rst_n = 1'b0;
        tick();
        chk("mid_clear_reset_done", 32'(init_done), 32'h0);
        rst_n = 1'b1;
        measure_init("reinit_cycles");
        idle(); a_set(1'b0, 4'd3, '0, 2'b00); b_set(1'b0, 4'd15, '0, 2'b00); tick();
        chk("recleared_a", 32'(a_dout), 32'h0000);
        chk("recleared_b", 32'(b_dout), 32'h0000);
        idle(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
